pcie_rx_tlp_demux: RTL and testbench
====================================

# pcie_rx_tlp_demux

Packet-level router placed directly downstream of the AXIS-RX PCIe pipeline register. Decodes the fmt/type field of each received TLP on its first beat and steers the whole packet to one of two AXIS-RX outputs:

- memory requests go to the MMIO request path;
- completions go to the DMA completion path;
- all other TLPs are discarded.

Each output has one skid-buffer stage, so both downstream consumers see registered, back-pressurable streams.

## Interface
Parameters:
- TREADY_RST_VAL, 0, output skid stages assert (1) or de-assert (0) s_tready during reset

Ports:
- clk  input  1  single clock for all logic
- rst_n  input  1  asynchronous, active-low reset
- s_if  input  t_axis_pcie_rx  upstream RX stream (tvalid, tdata[AXIS_PCIE_DW], tlast, tuser[AXIS_PCIE_RX_UW])
- s_if_tready  output  1  upstream ready
- m_req_if  output  t_axis_pcie_rx  memory-request TLP stream
- m_req_tready  input  1  request consumer ready
- m_cpl_if  output  t_axis_pcie_rx  completion TLP stream
- m_cpl_tready  input  1  completion consumer ready
- req_pkt_cnt  output  32  accepted request packets (statistics)
- cpl_pkt_cnt  output  32  accepted completion packets (statistics)
- drop_pkt_cnt  output  32  discarded packets (statistics)

## Operation
- The header is on the first beat of a packet. DW0 is tdata[31:0]; fmt is [31:29]; type is [28:24].
- Classification on the SOP beat:
  - type[4:1]==4'b0101 → CPL (Cpl, CplD, CplLk, CplDLk).
  - type[4:1]==4'b0000 → REQ (MRd, MWr, MRdLk).
  - anything else → DROP.
- FSM states: SOP, FWD_REQ, FWD_CPL, DISCARD. Reset state is SOP.
- In SOP, any valid beat is treated as the first beat of a packet; the class is decoded combinationally from that beat.
  - s_if_tready = target skid stage's s_tready; for DROP, s_if_tready = 1.
  - On handshake with tlast=0, go to FWD_REQ, FWD_CPL or DISCARD according to the class.
  - On handshake with tlast=1 (single-beat packet), stay in SOP.
- In FWD_x, every beat goes to port x only, and s_if_tready = that port's skid s_tready. The accepted beat carrying tlast=1 returns the FSM to SOP.
- In DISCARD, s_if_tready = 1 and beats are consumed with no output. tlast returns the FSM to SOP.
- The non-selected output never sees tvalid for the current packet.
- There is no reordering. The input stalls head-of-line while the target port is not ready.
- tdata, tlast and tuser pass through unmodified.

## Timing
- Input-to-output latency is 1 cycle per skid stage.
- Full throughput is 1 beat/clk per port while its tready is held high.
- Reset values:
  - m_req_if.tvalid = 0 and m_cpl_if.tvalid = 0.
  - FSM = SOP.
  - All counters = 0.
  - s_if_tready follows TREADY_RST_VAL while reset is asserted, 0 otherwise.
- Reset asserted mid-packet: the FSM returns to SOP and skid contents are flushed. The first valid beat after reset is decoded as a header.
- An output holds tvalid/tdata stable until its tready is sampled high (AXIS rule).
- A change of class between consecutive packets (REQ then CPL) takes no bubble cycle. The SOP beat of the next packet may be accepted in the cycle after the previous tlast.

## Configuration
- PCIE_RX_DEMUX_STATS_EN defined:
  - The three 32-bit counters increment by 1 on each accepted SOP beat of their class.
  - Counters saturate at 32'hFFFF_FFFF.
  - Counters are cleared only by rst_n.
- Not defined: the counter logic is not built and the counter ports are tied to 0.

## Structure
- Shared package ofs_fim_pcie_rx_demux_pkg holds:
  - the state enum t_rx_demux_state (SOP, FWD_REQ, FWD_CPL, DISCARD);
  - the class enum t_tlp_class (REQ, CPL, DROP);
  - constants TLP_TYPE_CPL_MSB4=4'b0101 and TLP_TYPE_MEM_MSB4=4'b0000.
- Sub-module: two instances of the existing ofs_fim_axis_register configured as follows:
  - MODE 0 (skid);
  - ENABLE_TLAST=1 and ENABLE_TUSER=1;
  - TDATA_WIDTH = AXIS_PCIE_DW and TUSER_WIDTH = AXIS_PCIE_RX_UW.
- The demux FSM, decode and counters live in this module.

## Test plan
- 3-beat MWr (type 5'b00000), both treadys = 1 → 3 beats appear on m_req_if at cycles 1-3 with identical tdata/tlast. m_cpl_if.tvalid stays 0. req_pkt_cnt = 1.
- 1-beat CplD (type 5'b01010, tlast on SOP) immediately followed by a 2-beat MRd → CplD appears on m_cpl_if, then MRd appears on m_req_if, with no idle input cycle. Counters are cpl = 1 and req = 1.
- 4-beat Msg (type 5'b10000) → s_if_tready = 1 for all 4 beats and no output tvalid. drop_pkt_cnt = 1. The next MWr is routed to m_req_if.
- 4-beat CplD with m_cpl_tready low for cycles 2-5 → s_if_tready drops after the skid stage fills. No beat is lost or duplicated. Output order is preserved and m_req_if stays idle.
- rst_n asserted during beat 2 of a 4-beat MWr, then released, then a CplD is sent → outputs go idle immediately. The CplD is routed to m_cpl_if and req_pkt_cnt is 0.
- With PCIE_RX_DEMUX_STATS_EN defined, req_pkt_cnt is forced (via hierarchical deposit) to 32'hFFFF_FFFE and 3 MRd packets are sent → the counter reads 32'hFFFF_FFFF and holds. Without the macro, all counters read 0.

Source files
------------

// File: rtl/pcie_rx_tlp_demux_pkg.sv
// pcie_rx_tlp_demux_pkg: shared types and constants for the PCIe RX TLP demux.
package ofs_fim_pcie_rx_demux_pkg;
  localparam int AXIS_PCIE_DW    = 64;
  localparam int AXIS_PCIE_RX_UW = 8;

  typedef struct packed {
    logic                       tvalid;
    logic [AXIS_PCIE_DW-1:0]    tdata;
    logic                       tlast;
    logic [AXIS_PCIE_RX_UW-1:0] tuser;
  } t_axis_pcie_rx;

  typedef enum logic [1:0] {SOP, FWD_REQ, FWD_CPL, DISCARD} t_rx_demux_state;
  typedef enum logic [1:0] {REQ, CPL, DROP} t_tlp_class;

  localparam logic [3:0] TLP_TYPE_CPL_MSB4 = 4'b0101;
  localparam logic [3:0] TLP_TYPE_MEM_MSB4 = 4'b0000;

  // The low type bit only distinguishes the locked variants, so it is ignored.
  function automatic t_tlp_class tlp_decode(input logic [4:0] typ);
    return typ[4:1] == TLP_TYPE_CPL_MSB4 ? CPL : typ[4:1] == TLP_TYPE_MEM_MSB4 ? REQ : DROP;
  endfunction
endpackage

// File: rtl/pcie_rx_tlp_demux_axis_register.sv
// ofs_fim_axis_register: AXIS register slice; MODE 0 is a full-throughput skid buffer, other modes bypass.
module ofs_fim_axis_register #(
  parameter int MODE           = 0,
  parameter bit TREADY_RST_VAL = 1'b0,
  parameter bit ENABLE_TLAST   = 1'b1,
  parameter bit ENABLE_TUSER   = 1'b1,
  parameter int TDATA_WIDTH    = 64,
  parameter int TUSER_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   s_tready,
  input  logic                   s_tvalid,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic [TUSER_WIDTH-1:0] s_tuser,
  input  logic                   m_tready,
  output logic                   m_tvalid,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [TUSER_WIDTH-1:0] m_tuser
);
  localparam int W = TDATA_WIDTH + 1 + TUSER_WIDTH;
  logic [W-1:0] s_pl, m_pl;
  assign s_pl = {s_tdata, ENABLE_TLAST ? s_tlast : 1'b0, ENABLE_TUSER ? s_tuser : {TUSER_WIDTH{1'b0}}};
  assign {m_tdata, m_tlast, m_tuser} = m_pl;
  if (MODE == 0) begin : g_skid
    logic out_v_q, out_v_d, sk_v_q, sk_v_d, rdy_q, pop, acc;
    logic [W-1:0] out_q, out_d, sk_q, sk_d;
    // Output stage reloads when empty or drained; a beat arriving while it stalls parks in the skid slot.
    always_comb begin
      pop     = m_tready | ~out_v_q;
      acc     = s_tvalid & rdy_q;
      out_v_d = pop ? (sk_v_q | acc) : out_v_q;
      out_d   = pop ? (sk_v_q ? sk_q : s_pl) : out_q;
      sk_v_d  = pop ? 1'b0 : (sk_v_q | acc);
      sk_d    = (!pop && acc) ? s_pl : sk_q;
    end
    // Registered ready is the inverse of skid occupancy, so it never depends on m_tready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_v_q <= 1'b0;
        sk_v_q  <= 1'b0;
        rdy_q   <= TREADY_RST_VAL;
        out_q   <= '0;
        sk_q    <= '0;
      end else begin
        out_v_q <= out_v_d;
        sk_v_q  <= sk_v_d;
        rdy_q   <= ~sk_v_d;
        out_q   <= out_d;
        sk_q    <= sk_d;
      end
    end
    assign s_tready = rdy_q;
    assign m_tvalid = out_v_q;
    assign m_pl     = out_q;
  end else begin : g_bypass
    assign s_tready = m_tready;
    assign m_tvalid = s_tvalid;
    assign m_pl     = s_pl;
  end
endmodule

// File: rtl/pcie_rx_tlp_demux.sv
// pcie_rx_tlp_demux: routes RX TLPs to request/completion streams by header type; optional stats via PCIE_RX_DEMUX_STATS_EN.
module pcie_rx_tlp_demux
  import ofs_fim_pcie_rx_demux_pkg::*;
#(
  parameter bit TREADY_RST_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  t_axis_pcie_rx s_if,
  output logic          s_if_tready,
  output t_axis_pcie_rx m_req_if,
  input  logic          m_req_tready,
  output t_axis_pcie_rx m_cpl_if,
  input  logic          m_cpl_tready,
  output logic [31:0]   req_pkt_cnt,
  output logic [31:0]   cpl_pkt_cnt,
  output logic [31:0]   drop_pkt_cnt
);
  t_rx_demux_state state_q, state_d;
  t_tlp_class      tgt;
  logic            hs, sel_rdy;
  logic [1:0]      sk_vin, sk_rdy, m_rdy, m_v, m_l;
  logic [1:0][AXIS_PCIE_DW-1:0]    m_d;
  logic [1:0][AXIS_PCIE_RX_UW-1:0] m_u;

  // Target is decoded live from the SOP beat and latched into the state for the rest of the packet.
  always_comb begin
    tgt         = state_q == FWD_REQ ? REQ : state_q == FWD_CPL ? CPL : state_q == DISCARD ? DROP : tlp_decode(s_if.tdata[28:24]);
    sel_rdy     = tgt == REQ ? sk_rdy[0] : tgt == CPL ? sk_rdy[1] : 1'b1;
    s_if_tready = rst_n ? sel_rdy : TREADY_RST_VAL;
    hs          = s_if.tvalid & s_if_tready;
    sk_vin      = {s_if.tvalid & (tgt == CPL), s_if.tvalid & (tgt == REQ)};
    state_d     = !hs ? state_q : s_if.tlast ? SOP : tgt == REQ ? FWD_REQ : tgt == CPL ? FWD_CPL : DISCARD;
  end

  // Packet-state register; reset mid-packet forces the next valid beat to be decoded as a header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SOP;
    else        state_q <= state_d;
  end

  assign m_rdy = {m_cpl_tready, m_req_tready};
  for (genvar g = 0; g < 2; g++) begin : g_sk
    ofs_fim_axis_register #(
      .MODE(0), .TREADY_RST_VAL(TREADY_RST_VAL), .ENABLE_TLAST(1'b1), .ENABLE_TUSER(1'b1),
      .TDATA_WIDTH(AXIS_PCIE_DW), .TUSER_WIDTH(AXIS_PCIE_RX_UW)
    ) u_reg (
      .clk, .rst_n,
      .s_tready(sk_rdy[g]), .s_tvalid(sk_vin[g]), .s_tdata(s_if.tdata), .s_tlast(s_if.tlast), .s_tuser(s_if.tuser),
      .m_tready(m_rdy[g]), .m_tvalid(m_v[g]), .m_tdata(m_d[g]), .m_tlast(m_l[g]), .m_tuser(m_u[g])
    );
  end
  assign m_req_if = {m_v[0], m_d[0], m_l[0], m_u[0]};
  assign m_cpl_if = {m_v[1], m_d[1], m_l[1], m_u[1]};

`ifdef PCIE_RX_DEMUX_STATS_EN
  logic [31:0] req_cnt_q, cpl_cnt_q, drop_cnt_q;
  logic        sop_hs;
  assign sop_hs = hs & (state_q == SOP);
  // Saturating per-class packet counters, bumped once per accepted header beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q  <= '0;
      cpl_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (sop_hs && tgt == REQ && ~&req_cnt_q)   req_cnt_q  <= req_cnt_q + 32'd1;
      if (sop_hs && tgt == CPL && ~&cpl_cnt_q)   cpl_cnt_q  <= cpl_cnt_q + 32'd1;
      if (sop_hs && tgt == DROP && ~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end
  assign req_pkt_cnt  = req_cnt_q;
  assign cpl_pkt_cnt  = cpl_cnt_q;
  assign drop_pkt_cnt = drop_cnt_q;
`else
  assign req_pkt_cnt  = '0;
  assign cpl_pkt_cnt  = '0;
  assign drop_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_pcie_rx_tlp_demux.sv
// tb_pcie_rx_tlp_demux: table-driven and scoreboarded bench for the RX TLP demux.
module tb_pcie_rx_tlp_demux;
  import ofs_fim_pcie_rx_demux_pkg::*;

  typedef struct packed {
    logic [AXIS_PCIE_DW-1:0]    d;
    logic                       l;
    logic [AXIS_PCIE_RX_UW-1:0] u;
  } beat_t;
  typedef struct {
    logic [4:0] typ;
    int         n;
    t_tlp_class cls;
  } pkt_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  t_axis_pcie_rx s_if, m_req_if, m_cpl_if;
  logic          s_if_tready, m_req_tready, m_cpl_tready;
  logic [31:0]   req_pkt_cnt, cpl_pkt_cnt, drop_pkt_cnt;

  int    total = 0, bad = 0;
  beat_t exp_req[$], exp_cpl[$];
  logic [31:0] m_req_cnt = 0, m_cpl_cnt = 0, m_drop_cnt = 0;
  bit    stall_seen = 0, rand_rdy = 0;
  int    cpl_out = 0;

  pcie_rx_tlp_demux #(.TREADY_RST_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(s_if), .s_if_tready(s_if_tready),
    .m_req_if(m_req_if), .m_req_tready(m_req_tready),
    .m_cpl_if(m_cpl_if), .m_cpl_tready(m_cpl_tready),
    .req_pkt_cnt(req_pkt_cnt), .cpl_pkt_cnt(cpl_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] m);
`ifdef PCIE_RX_DEMUX_STATS_EN
    return m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction

  task automatic check_cnts(input string tag);
    chk({tag, "_req_cnt"}, req_pkt_cnt, cnt_exp(m_req_cnt));
    chk({tag, "_cpl_cnt"}, cpl_pkt_cnt, cnt_exp(m_cpl_cnt));
    chk({tag, "_drop_cnt"}, drop_pkt_cnt, cnt_exp(m_drop_cnt));
  endtask

  // Drives one packet starting at posedge+1; expected beats are queued at each handshake.
  task automatic send_pkt(input logic [4:0] typ, input int n, input t_tlp_class cls, output int waits);
    beat_t bt;
    waits = 0;
    for (int b = 0; b < n; b++) begin
      bt.d = {$urandom(), $urandom()};
      if (b == 0) bt.d[28:24] = typ;
      bt.l = (b == n - 1);
      bt.u = AXIS_PCIE_RX_UW'($urandom());
      s_if = {1'b1, bt.d, bt.l, bt.u};
      for (int w = 0; ; w++) begin
        @(negedge clk);
        if (s_if_tready) break;
        waits++;
        if (w > 60) begin
          total++;
          bad++;
          $display("FAIL send_timeout: ready stuck low, got=0 expected=1");
          s_if = '0;
          return;
        end
      end
      if (cls == REQ) exp_req.push_back(bt);
      if (cls == CPL) exp_cpl.push_back(bt);
      if (b == 0) begin
        if (cls == REQ) m_req_cnt = sat_inc(m_req_cnt);
        if (cls == CPL) m_cpl_cnt = sat_inc(m_cpl_cnt);
        if (cls == DROP) m_drop_cnt = sat_inc(m_drop_cnt);
      end
      @(posedge clk);
      #1;
    end
    s_if = '0;
  endtask

  task automatic drain();
    rand_rdy = 0;
    m_req_tready = 1'b1;
    m_cpl_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("req_queue_empty", exp_req.size(), 0);
    chk("cpl_queue_empty", exp_cpl.size(), 0);
  endtask

  // Output monitor: pops the scoreboard at each output handshake, sampled at the falling edge.
  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n) begin
      if (s_if.tvalid && !s_if_tready) stall_seen = 1;
      if (m_req_if.tvalid && m_req_tready) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got beat %0h expected none", m_req_if.tdata);
        end else begin
          e = exp_req.pop_front();
          chk("req_beat", {m_req_if.tdata, m_req_if.tlast, m_req_if.tuser}, e);
        end
      end
      if (m_cpl_if.tvalid && m_cpl_tready) begin
        cpl_out++;
        if (exp_cpl.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cpl_unexpected: got beat %0h expected none", m_cpl_if.tdata);
        end else begin
          e = exp_cpl.pop_front();
          chk("cpl_beat", {m_cpl_if.tdata, m_cpl_if.tlast, m_cpl_if.tuser}, e);
        end
      end
    end
  end

  // Random consumer back-pressure for the second table pass.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      m_req_tready = 1'($urandom_range(0, 1));
      m_cpl_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    pkt_t tbl[10];
    int w, w2;
    beat_t bt;
    tbl = '{
      '{5'b00000, 2, REQ},  '{5'b00001, 1, REQ},  '{5'b01010, 3, CPL},  '{5'b01011, 1, CPL},
      '{5'b00100, 2, DROP}, '{5'b00010, 1, DROP}, '{5'b10000, 2, DROP}, '{5'b11011, 1, DROP},
      '{5'b01100, 2, DROP}, '{5'b00000, 4, REQ}
    };
    s_if = '0;
    m_req_tready = 1'b1;
    m_cpl_tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_tvalid", m_req_if.tvalid, 0);
    chk("rst_cpl_tvalid", m_cpl_if.tvalid, 0);
    chk("rst_s_tready", s_if_tready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_cnts("reset");

    // 3-beat MWr: one cycle latency through the request skid stage.
    send_pkt(5'b00000, 3, REQ, w);
    chk("mwr_last_out_valid", {m_req_if.tvalid, m_req_if.tlast}, 2'b11);
    chk("mwr_cpl_idle", m_cpl_if.tvalid, 0);
    drain();
    check_cnts("mwr");

    // 1-beat CplD immediately followed by 2-beat MRd: no bubble on the input.
    send_pkt(5'b01010, 1, CPL, w);
    send_pkt(5'b00000, 2, REQ, w2);
    chk("cpl_then_mrd_waits", w + w2, 0);
    drain();
    check_cnts("cpl_mrd");

    // 4-beat Msg is swallowed at full rate, then the next MWr routes normally.
    send_pkt(5'b10000, 4, DROP, w);
    chk("msg_drop_waits", w, 0);
    send_pkt(5'b00000, 2, REQ, w);
    drain();
    check_cnts("msg");

    // 4-beat CplD with the completion consumer stalled for four cycles.
    stall_seen = 0;
    cpl_out = 0;
    fork
      send_pkt(5'b01010, 4, CPL, w);
      begin
        repeat (2) @(posedge clk);
        #1 m_cpl_tready = 1'b0;
        repeat (4) @(posedge clk);
        #1 m_cpl_tready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_seen", stall_seen, 1);
    chk("bp_cpl_beats", cpl_out, 4);
    check_cnts("bp");

    // Table sweep, first with free-running consumers, then with random back-pressure.
    for (int p = 0; p < 2; p++) begin
      rand_rdy = (p == 1);
      foreach (tbl[i]) begin
        send_pkt(tbl[i].typ, tbl[i].n, tbl[i].cls, w);
        if (tbl[i].cls == DROP) chk("tbl_drop_waits", w, 0);
      end
      drain();
      check_cnts("table");
    end

    // Reset during beat 2 of a 4-beat MWr, then a CplD.
    bt.d = {$urandom(), $urandom()};
    bt.d[28:24] = 5'b00000;
    bt.l = 1'b0;
    bt.u = 8'h5a;
    s_if = {1'b1, bt.d, bt.l, bt.u};
    @(negedge clk);
    chk("rst_mid_sop_ready", s_if_tready, 1);
    exp_req.push_back(bt);
    @(posedge clk);
    #1 s_if.tdata = {$urandom(), $urandom()};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_idle", m_req_if.tvalid, 0);
    chk("rst_mid_cpl_idle", m_cpl_if.tvalid, 0);
    exp_req.delete();
    exp_cpl.delete();
    m_req_cnt = 0;
    m_cpl_cnt = 0;
    m_drop_cnt = 0;
    s_if = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_cnts("rst_mid");
    send_pkt(5'b01010, 1, CPL, w);
    drain();
    check_cnts("after_rst");

`ifdef PCIE_RX_DEMUX_STATS_EN
    // Saturation: preload the request counter just below the ceiling.
    @(negedge clk);
    dut.req_cnt_q <= 32'hFFFF_FFFE;
    m_req_cnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) send_pkt(5'b00000, 1, REQ, w);
    drain();
    chk("sat_req_cnt", req_pkt_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got=timeout expected=done");
    $fatal(1, "watchdog");
  end
endmodule
